// File: rtl/lut_truth_table_capture.sv
// Sweeps every input vector of an N-input LUT, rebuilds its INIT code from the
// sampled outputs and compares it against a latched expected INIT.
module lut_truth_table_capture #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2**N_IN-1:0]    EXP_INIT,
  input  logic                  O_IN,
  output logic [N_IN-1:0]       I_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [2**N_IN-1:0]    INIT,
  output logic                  MATCH,
  output logic [N_IN-1:0]       MISMATCH_IDX
);
  localparam int W = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_MAX  = N_IN'(W-1);
  localparam logic [3:0]      WAIT_MAX = 4'(SETTLE-1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      wait_q, wait_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    init_q, init_d;
  logic [N_IN-1:0] midx_q, midx_d;
  logic            seen_q, seen_d;
  logic            match_q, match_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            miss;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      exp_q   <= '0;
      init_q  <= '0;
      midx_q  <= '0;
      seen_q  <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      exp_q   <= exp_d;
      init_q  <= init_d;
      midx_q  <= midx_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    exp_d   = exp_q;
    init_d  = init_q;
    midx_d  = midx_q;
    seen_d  = seen_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    miss    = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        exp_d   = EXP_INIT;
        init_d  = '0;
        match_d = 1'b0;
        midx_d  = '0;
        seen_d  = 1'b0;
        idx_d   = '0;
        wait_d  = '0;
        busy_d  = 1'b1;
        state_d = DRIVE;
      end
      DRIVE: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == WAIT_MAX) state_d = SAMPLE;
      end
      SAMPLE: begin
        init_d[idx_q] = O_IN;
        miss = (O_IN != exp_q[idx_q]);
        if (miss && !seen_q) begin
          midx_d = idx_q;
          seen_d = 1'b1;
        end
        if (idx_q == IDX_MAX) begin
          // Fold in the last vector's outcome so MATCH is valid with DONE.
          match_d = !(seen_q || miss);
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          wait_d  = '0;
          state_d = DRIVE;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign I_OUT        = idx_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign INIT         = init_q;
  assign MATCH        = match_q;
  assign MISMATCH_IDX = midx_q;
endmodule

// File: tb/tb_lut_truth_table_capture.sv
// Directed bench: two characterizer instances (4-input/SETTLE=1, 3-input/SETTLE=2)
// each driving an emulated LUT, with hand-computed INIT/timing expectations.
module tb_lut_truth_table_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // 4-input instance
  logic        rst, st_a, o_a, busy_a, done_a, match_a;
  logic [15:0] exp_a, lut_a, init_a;
  logic [3:0]  i_a, midx_a;
  // 3-input instance
  logic        st_b, o_b, busy_b, done_b, match_b;
  logic [7:0]  exp_b, lut_b, init_b;
  logic [2:0]  i_b, midx_b;

  assign o_a = lut_a[i_a];
  assign o_b = lut_b[i_b];

  lut_truth_table_capture #(.N_IN(4), .SETTLE(1)) u_a (
    .CLK(clk), .RST(rst), .START(st_a), .EXP_INIT(exp_a), .O_IN(o_a),
    .I_OUT(i_a), .BUSY(busy_a), .DONE(done_a), .INIT(init_a),
    .MATCH(match_a), .MISMATCH_IDX(midx_a));

  lut_truth_table_capture #(.N_IN(3), .SETTLE(2)) u_b (
    .CLK(clk), .RST(rst), .START(st_b), .EXP_INIT(exp_b), .O_IN(o_b),
    .I_OUT(i_b), .BUSY(busy_b), .DONE(done_b), .INIT(init_b),
    .MATCH(match_b), .MISMATCH_IDX(midx_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents START for one edge (edge 0 of the sweep).
  task automatic start_a(input logic [15:0] lutv, input logic [15:0] e);
    lut_a = lutv;
    exp_a = e;
    st_a  = 1'b1;
    tick();
    st_a  = 1'b0;
  endtask

  // Runs edges 1..33 of a started 4-input sweep, checking DONE/BUSY timing.
  task automatic finish_a(input string tag);
    repeat (31) tick();
    chk({tag, "_done_early"}, done_a, 1'b0);
    tick();
    chk({tag, "_done"}, done_a, 1'b1);
    chk({tag, "_busy_fin"}, busy_a, 1'b1);
    tick();
    chk({tag, "_done_off"}, done_a, 1'b0);
    chk({tag, "_busy_off"}, busy_a, 1'b0);
  endtask

  initial begin
    int dcnt, dedge;
    rst = 1'b1; st_a = 1'b0; st_b = 1'b0;
    exp_a = '0; lut_a = '0; exp_b = '0; lut_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_iout", i_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_init", init_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_midx", midx_a, 0);
    chk("rst_b_busy", busy_b, 0);

    // XOR4 parity
    start_a(16'h6996, 16'h6996);
    chk("xor_busy0", busy_a, 1);
    finish_a("xor");
    chk("xor_init", init_a, 16'h6996);
    chk("xor_match", match_a, 1);
    chk("xor_midx", midx_a, 0);

    // Mismatch at bit 3, then only at bit 15
    start_a(16'h7888, 16'h7880);
    finish_a("mis3");
    chk("mis3_init", init_a, 16'h7888);
    chk("mis3_match", match_a, 0);
    chk("mis3_midx", midx_a, 3);
    start_a(16'h7888, 16'hF888);
    finish_a("mis15");
    chk("mis15_match", match_a, 0);
    chk("mis15_midx", midx_a, 15);

    // 3-input, SETTLE=2: each vector held 3 cycles, DONE after edge 24
    lut_b = 8'hAC; exp_b = 8'hAC; st_b = 1'b1;
    tick();
    st_b = 1'b0;
    chk("b_iout0", i_b, 0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("b_iout_e%0d", k), i_b, (k < 24) ? (k / 3) : 7);
      if (k == 23) chk("b_done_early", done_b, 0);
    end
    chk("b_done", done_b, 1);
    chk("b_match", match_b, 1);
    chk("b_init", init_b, 8'hAC);
    chk("b_midx", midx_b, 0);
    tick();
    chk("b_busy_off", busy_b, 0);

    // Reset at edge 10 of a sweep
    start_a(16'h6996, 16'h6996);
    repeat (9) tick();
    chk("rsw_busy_pre", busy_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsw_busy", busy_a, 0);
    chk("rsw_iout", i_a, 0);
    chk("rsw_init", init_a, 0);
    chk("rsw_match", match_a, 0);
    chk("rsw_midx", midx_a, 0);
    start_a(16'h6996, 16'h6996);
    finish_a("rsw2");
    chk("rsw2_init", init_a, 16'h6996);
    chk("rsw2_match", match_a, 1);

    // START pulses at edges 5 and 20 with a changed EXP must be ignored
    start_a(16'h7888, 16'h7888);
    exp_a = 16'h0000;
    dcnt = 0; dedge = 0;
    for (int k = 1; k <= 40; k++) begin
      st_a = (k == 5 || k == 20);
      tick();
      if (done_a) begin
        dcnt++;
        dedge = k;
      end
    end
    st_a = 1'b0;
    chk("busy_start_dcnt", dcnt, 1);
    chk("busy_start_edge", dedge, 32);
    chk("busy_start_match", match_a, 1);
    chk("busy_start_init", init_a, 16'h7888);
    chk("busy_start_idle", busy_a, 0);

    // START held high: next sweep accepted one IDLE cycle after FINISH
    lut_a = 16'h6996; exp_a = 16'h6996; st_a = 1'b1;
    tick();
    repeat (31) tick();
    chk("held_done_early", done_a, 0);
    tick();
    chk("held_done", done_a, 1);
    chk("held_init", init_a, 16'h6996);
    tick();
    chk("held_idle_busy", busy_a, 0);
    tick();
    chk("held_rebusy", busy_a, 1);
    chk("held_reinit", init_a, 0);
    chk("held_reiout", i_a, 0);
    st_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
